keypad_decoder: RTL and testbench
=================================

# keypad_decoder

Scans a 4x4 matrix keypad, debounces one key at a time and translates it into the calculator's command interface. Digits are delivered as a one-cycle `read_input` pulse with a 4-bit value. Operator and equals keys are delivered as held levels. The block sits directly upstream of the calculator controller and drives its `keypad_input`, `read_input`, `operator_input` and `equal_input` ports.

## Interface
- `SCAN_DIV`, 8: cycles each column is driven during scanning. Must be ≥ 4.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required for both press and release. Must be ≥ 1.
- `REPEAT_CYCLES`, 1000: autorepeat interval. Used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk` in 1: single clock.
- `nRST` in 1: reset. One clock; reset is synchronous and active-high. 1 = reset, sampled on rising `clk`.
- `rows` in 4: keypad rows. Active-low, externally pulled up, asynchronous.
- `cols` out 4: column drive. Active-low, exactly one bit low at all times.
- `keypad_input` out 4: last digit value, 0–9. Valid while `read_input` = 1; held otherwise.
- `read_input` out 1: one-cycle pulse per accepted digit.
- `operator_input` out 3: 001 add, 010 sub, 100 mult, 000 none. Level.
- `equal_input` out 1: level, set by '#'.
- `clear_pulse` out 1: one-cycle pulse on '*'.

## Operation
- `rows` pass through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- Key map, by (row, col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Key actions:
  - A → 001, B → 010, C → 100.
  - '#' → equal.
  - '*' → clear.
  - D is accepted and debounced but produces no action.
- FSM `SCAN → DEBOUNCE → EMIT → RELEASE → SCAN`.
  - **SCAN:** a slot counter counts 0..SCAN_DIV-1. At the wrap, `cols` rotates 1110 → 1101 → 1011 → 0111 → 1110. `rs` is evaluated only in the last cycle of each slot. If any `rs` bit is 0, capture the column and the lowest-index low row, then go to DEBOUNCE. The column stays driven.
  - **DEBOUNCE:** count cycles where `rs` equals the captured pattern. On any mismatch, return to SCAN, which resumes with the next column. When the count reaches DEBOUNCE_CYCLES, go to EMIT.
  - **EMIT:** one cycle. Perform the key action, then go to RELEASE.
  - **RELEASE:** the column stays driven. Count consecutive cycles with `rs` = 1111; any 0 restarts the count. At DEBOUNCE_CYCLES, go to SCAN with the slot counter at 0 and the next column.
- Multiple keys pressed: only the captured key acts. Other keys are ignored until release.
- Level rules:
  - An operator key overwrites `operator_input`.
  - '#' sets `equal_input`.
  - A digit pressed while `equal_input` = 1 clears `equal_input` and `operator_input` in the same cycle its `read_input` pulses.
  - '*' clears `operator_input`, `equal_input` and `keypad_input` to 0 while pulsing `clear_pulse`.
  - A second '#' while `equal_input` = 1 leaves it at 1.

## Timing
- Reset values:
  - `cols` = 1110; state SCAN; all counters 0.
  - `keypad_input` = 0, `read_input` = 0, `operator_input` = 000, `equal_input` = 0, `clear_pulse` = 0.
  - Synchronizer flops = 1111.
- Reset asserted mid-operation, in any state, returns to these values on the next edge. Any pending pulse is dropped.
- Detection occurs in cycle t, the last SCAN slot cycle.
  - DEBOUNCE occupies t+1..t+DEBOUNCE_CYCLES.
  - Outputs are registered. Pulses and level changes are visible in cycle t+DEBOUNCE_CYCLES+1 and nowhere else.
- Physical press to detection is at most 2 (sync) + 4·SCAN_DIV cycles.
- Release: after `rs` goes to 1111, scanning resumes DEBOUNCE_CYCLES+1 cycles later.
- `read_input` and `clear_pulse` are never high in the same cycle. Each is at most one cycle wide per EMIT.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In RELEASE, a held digit key (only digits) re-enters EMIT every REPEAT_CYCLES cycles measured from the previous pulse.
  - Each entry produces a new `read_input` pulse with the same value.
  - The release-count rules are unchanged.
- Undefined: exactly one action per press. `REPEAT_CYCLES` is unused and no repeat counter is synthesized.

## Test plan
All scenarios use SCAN_DIV = 8, DEBOUNCE_CYCLES = 4.
- **Reset:** assert `nRST` for 2 cycles with '5' held → all outputs at reset values, `cols` = 1110, no pulse until a full scan completes after release of `nRST`.
- **Digit:** press '7' (r2, c0) cleanly → exactly one `read_input` pulse with `keypad_input` = 7, 5 cycles after detection. Holding the key 200 cycles gives no further pulse (macro off).
- **Bounce:** '3' toggles every 2 cycles for 20 cycles, then stable → no pulse during bounce, exactly one pulse with value 3 after it settles.
- **Operator/equal sequence:** '1', C, '2', '#', '4' → `operator_input` = 100 after C; `equal_input` = 1 after '#'; on '4', `read_input` pulses with `keypad_input` = 4 while `operator_input` = 000 and `equal_input` = 0.
- **Clear and simultaneous keys:** 'A' then '*' → `operator_input` 001 → 000 with one `clear_pulse`. With '4' (r1) and '7' (r2) pressed together on c0 → only 4 is emitted.
- **Autorepeat (macro on, REPEAT_CYCLES = 50):** hold '9' for 180 cycles after the first pulse → 4 pulses total, spaced 50 cycles apart, each with value 9.

Source files
------------

// File: rtl/keypad_decoder_if.sv
// keypad_decoder_if: command bundle from the keypad decoder to the calculator
// controller, plus the decoder's FSM state for observation.
//
// Handshake: read_input and clear_pulse are one-cycle valid strobes with no
// ready/back-pressure; the consumer must take them in the cycle they are high.
// keypad_input is qualified by read_input and holds its value otherwise.
// operator_input and equal_input are plain levels, not strobes.
interface keypad_decoder_if;
  logic [3:0] keypad_input;
  logic       read_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       clear_pulse;
  logic [1:0] dbg_state;

  modport master (
    output keypad_input, read_input, operator_input, equal_input, clear_pulse, dbg_state
  );
  modport slave (
    input  keypad_input, read_input, operator_input, equal_input, clear_pulse, dbg_state
  );
endinterface

// File: rtl/keypad_decoder.sv
// keypad_decoder: scans a 4x4 active-low matrix keypad, debounces one key at a
// time and turns it into calculator commands (digit strobe, operator level,
// equal level, clear strobe).
// Optional build macro: KEYPAD_AUTOREPEAT_EN -- a held digit key re-emits its
// digit every REPEAT_CYCLES cycles while in the release phase.
// nRST is active-high and synchronous despite its name.
module keypad_decoder #(
  parameter int unsigned SCAN_DIV        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic [3:0]              rows,
  output logic [3:0]              cols,
  keypad_decoder_if.master        kp
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DB_DONE   = CNT_W'(DEBOUNCE_CYCLES);

  // Key codes: 0..9 are digits, the rest are the function keys.
  localparam logic [3:0] K_A    = 4'd10;
  localparam logic [3:0] K_B    = 4'd11;
  localparam logic [3:0] K_C    = 4'd12;
  localparam logic [3:0] K_D    = 4'd13;
  localparam logic [3:0] K_STAR = 4'd14;
  localparam logic [3:0] K_HASH = 4'd15;

  // Parameter sanity checks at elaboration.
  if (SCAN_DIV < 4) begin : g_chk_scan_div
    $error("keypad_decoder: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("keypad_decoder: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 2) begin : g_chk_repeat
    $error("keypad_decoder: REPEAT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync1_d;
  logic [3:0]        rs_q, rs_d;
  logic [3:0]        cols_q, cols_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        cap_row_q, cap_row_d;
  logic [1:0]        cap_col_q, cap_col_d;
  logic [3:0]        cap_pat_q, cap_pat_d;
  logic [3:0]        keypad_q, keypad_d;
  logic              read_q, read_d;
  logic [2:0]        op_q, op_d;
  logic              eq_q, eq_d;
  logic              clear_q, clear_d;

  logic              emit_go;
  logic [3:0]        code;
  logic [3:0]        cols_next;
  logic [1:0]        col_idx;
  logic [1:0]        low_row;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REPEAT_CYCLES);
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              is_digit;
`endif

  // Map a (row, col) position of the matrix to its key code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'd1;
      4'b00_01: k = 4'd2;
      4'b00_10: k = 4'd3;
      4'b00_11: k = K_A;
      4'b01_00: k = 4'd4;
      4'b01_01: k = 4'd5;
      4'b01_10: k = 4'd6;
      4'b01_11: k = K_B;
      4'b10_00: k = 4'd7;
      4'b10_01: k = 4'd8;
      4'b10_10: k = 4'd9;
      4'b10_11: k = K_C;
      4'b11_00: k = K_STAR;
      4'b11_01: k = 4'd0;
      4'b11_10: k = K_HASH;
      default:  k = K_D;
    endcase
    return k;
  endfunction

  // Helpers: driven column index, lowest low row, next column, captured key.
  always_comb begin
    col_idx   = 2'd0;
    low_row   = 2'd3;
    cols_next = {cols_q[2:0], cols_q[3]};
    case (cols_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    if (!rs_q[0])      low_row = 2'd0;
    else if (!rs_q[1]) low_row = 2'd1;
    else if (!rs_q[2]) low_row = 2'd2;
    else               low_row = 2'd3;
    code = key_code(cap_row_q, cap_col_q);
  end

  // Next-state logic for the scan FSM and the registered command outputs.
  always_comb begin
    state_d   = state_q;
    sync1_d   = rows;
    rs_d      = sync1_q;
    cols_d    = cols_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    cap_row_d = cap_row_q;
    cap_col_d = cap_col_q;
    cap_pat_d = cap_pat_q;
    keypad_d  = keypad_q;
    read_d    = 1'b0;
    op_d      = op_q;
    eq_d      = eq_q;
    clear_d   = 1'b0;
    emit_go   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d     = rep_q;
    is_digit  = (code <= 4'd9);
`endif

    case (state_q)
      ST_SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (rs_q != 4'hF) begin
            // Keep this column driven while the key is debounced.
            cap_col_d = col_idx;
            cap_row_d = low_row;
            cap_pat_d = rs_q;
            cnt_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            cols_d = cols_next;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (rs_q == cap_pat_q) begin
          if (cnt_q == DB_LAST) begin
            // Outputs are computed here so they are visible during EMIT.
            emit_go = 1'b1;
            cnt_d   = '0;
            state_d = ST_EMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          slot_d  = '0;
          cols_d  = cols_next;
          state_d = ST_SCAN;
        end
      end

      ST_EMIT: begin
        cnt_d   = '0;
        state_d = ST_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = REP_W'(1);
`endif
      end

      default: begin // ST_RELEASE
        if (cnt_q == DB_DONE) begin
          cnt_d   = '0;
          slot_d  = '0;
          cols_d  = cols_next;
          state_d = ST_SCAN;
        end else begin
          cnt_d = (rs_q == 4'hF) ? cnt_q + 1'b1 : '0;
`ifdef KEYPAD_AUTOREPEAT_EN
          rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + 1'b1;
          // Repeat pulse lands exactly REPEAT_CYCLES after the previous one.
          if (is_digit && !rs_q[cap_row_q] && (rep_q == REP_LAST)) begin
            emit_go = 1'b1;
            cnt_d   = '0;
            state_d = ST_EMIT;
          end
`endif
        end
      end
    endcase

    // Key action for the accepted key.
    if (emit_go) begin
      if (code <= 4'd9) begin
        keypad_d = code;
        read_d   = 1'b1;
        if (eq_q) begin
          eq_d = 1'b0;
          op_d = 3'b000;
        end
      end else if (code == K_A) begin
        op_d = 3'b001;
      end else if (code == K_B) begin
        op_d = 3'b010;
      end else if (code == K_C) begin
        op_d = 3'b100;
      end else if (code == K_HASH) begin
        eq_d = 1'b1;
      end else if (code == K_STAR) begin
        op_d     = 3'b000;
        eq_d     = 1'b0;
        keypad_d = 4'd0;
        clear_d  = 1'b1;
      end
      // K_D: accepted, no action.
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (nRST) begin
      state_q   <= ST_SCAN;
      sync1_q   <= 4'hF;
      rs_q      <= 4'hF;
      cols_q    <= 4'b1110;
      slot_q    <= '0;
      cnt_q     <= '0;
      cap_row_q <= 2'd0;
      cap_col_q <= 2'd0;
      cap_pat_q <= 4'hF;
      keypad_q  <= 4'd0;
      read_q    <= 1'b0;
      op_q      <= 3'b000;
      eq_q      <= 1'b0;
      clear_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rs_q      <= rs_d;
      cols_q    <= cols_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      cap_row_q <= cap_row_d;
      cap_col_q <= cap_col_d;
      cap_pat_q <= cap_pat_d;
      keypad_q  <= keypad_d;
      read_q    <= read_d;
      op_q      <= op_d;
      eq_q      <= eq_d;
      clear_q   <= clear_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign cols              = cols_q;
  assign kp.keypad_input   = keypad_q;
  assign kp.read_input     = read_q;
  assign kp.operator_input = op_q;
  assign kp.equal_input    = eq_q;
  assign kp.clear_pulse    = clear_q;
  assign kp.dbg_state      = state_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: drives a physical keypad model against keypad_decoder and
// checks command outputs against a key-level reference model.
`timescale 1ns/1ps
module tb_keypad_decoder;
  localparam int SD     = 8;
  localparam int DB     = 4;
  localparam int RC     = 50;
  localparam int SETTLE = 24;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_LONG = 45;
`else
  localparam int HOLD_LONG = 200;
`endif
  localparam int HOLD = 45;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] key_down = '0;
  int          cyc = 0;

  keypad_decoder_if kif();

  keypad_decoder #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RC)) dut (
    .clk  (clk),
    .nRST (nRST),
    .rows (rows),
    .cols (cols),
    .kp   (kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical matrix: a pressed key pulls its row low when its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && (cols[c] === 1'b0)) rows[r] = 1'b0;
  end

  // ---------------- counters / observation ----------------
  int total = 0;
  int bad   = 0;
  int overlap_cnt = 0;
  int wide_cnt = 0;
  logic prev_read = 1'b0;
  logic prev_clr  = 1'b0;
  logic [8:0] obs_q[$];   // {clear, keypad, operator, equal} at each strobe
  int         obs_t[$];

  always @(negedge clk) begin
    if (nRST === 1'b0) begin
      if (kif.read_input === 1'b1 && kif.clear_pulse === 1'b1) overlap_cnt++;
      if ((kif.read_input === 1'b1 && prev_read) || (kif.clear_pulse === 1'b1 && prev_clr)) wide_cnt++;
      if (kif.read_input === 1'b1 || kif.clear_pulse === 1'b1) begin
        obs_q.push_back({kif.clear_pulse, kif.keypad_input, kif.operator_input, kif.equal_input});
        obs_t.push_back(cyc);
      end
    end
    prev_read = (kif.read_input === 1'b1);
    prev_clr  = (kif.clear_pulse === 1'b1);
  end

  // ---------------- reference model ----------------
  // Key code per matrix index r*4+c: 0..9 digits, 10 A, 11 B, 12 C, 13 D, 14 '*', 15 '#'.
  int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0] m_val = 4'd0;
  logic [2:0] m_op  = 3'b000;
  logic       m_eq  = 1'b0;
  logic [8:0] exp_q[$];

  function automatic void model_reset();
    m_val = 4'd0; m_op = 3'b000; m_eq = 1'b0;
  endfunction

  function automatic void model_key(input int code);
    if (code <= 9) begin
      if (m_eq) begin m_eq = 1'b0; m_op = 3'b000; end
      m_val = 4'(code);
      exp_q.push_back({1'b0, m_val, m_op, m_eq});
    end else if (code == 10) m_op = 3'b001;
    else if (code == 11) m_op = 3'b010;
    else if (code == 12) m_op = 3'b100;
    else if (code == 15) m_eq = 1'b1;
    else if (code == 14) begin
      m_op = 3'b000; m_eq = 1'b0; m_val = 4'd0;
      exp_q.push_back({1'b1, 4'd0, 3'b000, 1'b0});
    end
  endfunction

  function automatic void clear_obs();
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic press(input int idx, input int hold);
    @(posedge clk); #1;
    key_down[idx] = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    key_down[idx] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first;
    logic [3:0] val;
    val = 4'd0;
    key_down = '0;
    key_down[5] = 1'b1;   // '5' at r1,c1 held through reset
    nRST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (cols !== 4'b1110) begin bad++; $display("FAIL rst_cols got=%b exp=1110", cols); end
    if (kif.keypad_input !== 4'd0) begin bad++; $display("FAIL rst_keypad got=%0d exp=0", kif.keypad_input); end
    if (kif.read_input !== 1'b0) begin bad++; $display("FAIL rst_read got=%b exp=0", kif.read_input); end
    if (kif.operator_input !== 3'b000) begin bad++; $display("FAIL rst_op got=%b exp=000", kif.operator_input); end
    if (kif.equal_input !== 1'b0) begin bad++; $display("FAIL rst_eq got=%b exp=0", kif.equal_input); end
    if (kif.clear_pulse !== 1'b0) begin bad++; $display("FAIL rst_clear got=%b exp=0", kif.clear_pulse); end
    nRST = 1'b0;
    clear_obs();
    first = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (first < 0 && kif.read_input === 1'b1) begin first = k; val = kif.keypad_input; end
    end
    #1;
    key_down[5] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
    // Column 1 is evaluated at the end of the second slot, then debounce + 1.
    total += 3;
    if (first != 2*SD - 1 + DB + 1) begin bad++; $display("FAIL rst_first_pulse got=%0d exp=%0d", first, 2*SD - 1 + DB + 1); end
    if (val !== 4'd5) begin bad++; $display("FAIL rst_first_val got=%0d exp=5", val); end
    if (obs_q.size() != 1) begin bad++; $display("FAIL rst_pulse_count got=%0d exp=1", obs_q.size()); end
    model_reset();
    m_val = 4'd5;
    clear_obs();
  endtask

  task automatic test_reset_mid();
    int waited;
    press(14, HOLD);           // '#'
    model_key(km[14]);
    @(posedge clk); #1;
    key_down[3] = 1'b1;        // 'A' held
    waited = 0;
    while (kif.operator_input !== 3'b001 && waited < 80) begin @(negedge clk); waited++; end
    total++;
    if (waited >= 80) begin bad++; $display("FAIL mid_wait_op got=%b exp=001", kif.operator_input); end
    @(posedge clk); #1;
    nRST = 1'b1;
    key_down = '0;
    @(posedge clk); #1;
    total += 5;
    if (kif.operator_input !== 3'b000) begin bad++; $display("FAIL mid_rst_op got=%b exp=000", kif.operator_input); end
    if (kif.equal_input !== 1'b0) begin bad++; $display("FAIL mid_rst_eq got=%b exp=0", kif.equal_input); end
    if (kif.keypad_input !== 4'd0) begin bad++; $display("FAIL mid_rst_keypad got=%0d exp=0", kif.keypad_input); end
    if (cols !== 4'b1110) begin bad++; $display("FAIL mid_rst_cols got=%b exp=1110", cols); end
    if (kif.read_input !== 1'b0 || kif.clear_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_pulses got=%b%b exp=00", kif.read_input, kif.clear_pulse); end
    nRST = 1'b0;
    model_reset();
    clear_obs();
    repeat (60) @(posedge clk);
    #1;
    total += 2;
    if (obs_q.size() != 0) begin bad++; $display("FAIL mid_no_pulse got=%0d exp=0", obs_q.size()); end
    if (kif.operator_input !== 3'b000) begin bad++; $display("FAIL mid_after_op got=%b exp=000", kif.operator_input); end
    clear_obs();
  endtask

  task automatic test_digit();
    int t0, lat;
    logic [8:0] e;
    @(posedge clk); #1;
    t0 = cyc;
    key_down[8] = 1'b1;        // '7' at r2,c0
    repeat (HOLD_LONG) @(posedge clk);
    #1;
    key_down[8] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
    model_key(km[8]);
    e = exp_q.pop_front();
    total += 4;
    if (obs_q.size() != 1) begin bad++; $display("FAIL digit_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0 && obs_q[0] !== e) begin bad++; $display("FAIL digit_record got=%h exp=%h", obs_q[0], e); end
    lat = (obs_t.size() > 0) ? obs_t[0] - t0 : -1;
    if (lat < DB + 1 || lat > 2 + 4*SD + DB + 2) begin bad++; $display("FAIL digit_latency got=%0d exp=%0d..%0d", lat, DB + 1, 2 + 4*SD + DB + 2); end
    if (kif.keypad_input !== m_val) begin bad++; $display("FAIL digit_held got=%0d exp=%0d", kif.keypad_input, m_val); end
    clear_obs();
  endtask

  task automatic test_bounce();
    logic [8:0] e;
    repeat ($urandom_range(0, 7)) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      key_down[2] = (i % 2 == 0);   // '3' at r0,c2 toggles every 2 cycles
      repeat (2) @(posedge clk);
      #1;
    end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("FAIL bounce_quiet got=%0d exp=0", obs_q.size()); end
    key_down[2] = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
    key_down[2] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
    model_key(km[2]);
    e = exp_q.pop_front();
    total += 2;
    if (obs_q.size() != 1) begin bad++; $display("FAIL bounce_count got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0 && obs_q[0] !== e) begin bad++; $display("FAIL bounce_record got=%h exp=%h", obs_q[0], e); end
    clear_obs();
  endtask

  task automatic test_op_eq_sequence();
    int seq[5] = '{0, 11, 1, 14, 4};   // '1', C, '2', '#', '4'
    logic [8:0] e, o;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        total += 2;
        if (kif.operator_input !== 3'b100) begin bad++; $display("FAIL seq_pre4_op got=%b exp=100", kif.operator_input); end
        if (kif.equal_input !== 1'b1) begin bad++; $display("FAIL seq_pre4_eq got=%b exp=1", kif.equal_input); end
      end
      press(seq[i], HOLD);
      model_key(km[seq[i]]);
      total += 2;
      if (kif.operator_input !== m_op) begin bad++; $display("FAIL seq_op step=%0d got=%b exp=%b", i, kif.operator_input, m_op); end
      if (kif.equal_input !== m_eq) begin bad++; $display("FAIL seq_eq step=%0d got=%b exp=%b", i, kif.equal_input, m_eq); end
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL seq_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL seq_record got=%h exp=%h", o, e); end
    end
    clear_obs();
  endtask

  task automatic test_clear_simul();
    logic [8:0] e, o;
    press(3, HOLD);            // 'A'
    model_key(km[3]);
    total++;
    if (kif.operator_input !== 3'b001) begin bad++; $display("FAIL clr_op_a got=%b exp=001", kif.operator_input); end
    press(12, HOLD);           // '*'
    model_key(km[12]);
    total += 2;
    if (kif.operator_input !== 3'b000) begin bad++; $display("FAIL clr_op got=%b exp=000", kif.operator_input); end
    if (kif.keypad_input !== 4'd0) begin bad++; $display("FAIL clr_keypad got=%0d exp=0", kif.keypad_input); end
    @(posedge clk); #1;
    key_down[4] = 1'b1;        // '4' r1,c0
    key_down[8] = 1'b1;        // '7' r2,c0
    repeat (HOLD) @(posedge clk);
    #1;
    key_down = '0;
    repeat (SETTLE) @(posedge clk);
    #1;
    model_key(km[4]);          // lowest row wins
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL clr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL clr_record got=%h exp=%h", o, e); end
    end
    clear_obs();
  endtask

  task automatic test_random();
    int idx;
    logic [8:0] e, o;
    for (int n = 0; n < 16; n++) begin
      idx = $urandom_range(0, 15);
      press(idx, HOLD);
      model_key(km[idx]);
      total += 3;
      if (kif.operator_input !== m_op) begin bad++; $display("FAIL rnd_op n=%0d key=%0d got=%b exp=%b", n, idx, kif.operator_input, m_op); end
      if (kif.equal_input !== m_eq) begin bad++; $display("FAIL rnd_eq n=%0d key=%0d got=%b exp=%b", n, idx, kif.equal_input, m_eq); end
      if (kif.keypad_input !== m_val) begin bad++; $display("FAIL rnd_val n=%0d key=%0d got=%0d exp=%0d", n, idx, kif.keypad_input, m_val); end
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL rnd_record got=%h exp=%h", o, e); end
    end
    clear_obs();
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int waited;
    @(posedge clk); #1;
    key_down[10] = 1'b1;       // '9' r2,c2
    waited = 0;
    while (obs_q.size() == 0 && waited < 60) begin @(posedge clk); waited++; end
    total++;
    if (waited >= 60) begin bad++; $display("FAIL rep_first got=none exp=pulse"); end
    repeat (180) @(posedge clk);
    #1;
    key_down[10] = 1'b0;
    repeat (SETTLE) @(posedge clk);
    #1;
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL rep_count got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i][7:4] !== 4'd9 || obs_q[i][8] !== 1'b0) begin bad++; $display("FAIL rep_val i=%0d got=%h exp=9", i, obs_q[i]); end
      if (i > 0) begin
        total++;
        if (obs_t[i] - obs_t[i-1] != RC) begin bad++; $display("FAIL rep_gap i=%0d got=%0d exp=%0d", i, obs_t[i] - obs_t[i-1], RC); end
      end
    end
    clear_obs();
  endtask
`endif

  task automatic test_pulse_props();
    total += 2;
    if (overlap_cnt != 0) begin bad++; $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt); end
    if (wide_cnt != 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid();
    test_digit();
    test_bounce();
    test_op_eq_sequence();
    test_clear_simul();
    test_random();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_pulse_props();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
